// File: rtl/return_stack.sv
`default_nettype none
// ============================================================================
// Module      : return_stack
// Description : Hardware return-address stack with occupancy status and
//               sticky overflow/underflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module return_stack #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] pushData,
    input  logic              clrErr,
    output logic [ADDR_W-1:0] top,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0]  r_mem [DEPTH];
    logic [CNT_W-1:0]   r_count;
    logic               r_overflow;
    logic               r_underflow;

    logic               w_empty;
    logic               w_full;
    logic [c_PTR_W-1:0] w_wr_idx;
    logic [c_PTR_W-1:0] w_top_idx;
    logic               w_mem_we;
    logic [c_PTR_W-1:0] w_mem_idx;
    logic [CNT_W-1:0]   w_next_count;
    logic               w_set_ovf;
    logic               w_set_udf;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_wr_idx  = r_count[c_PTR_W-1:0];
    assign w_top_idx = r_count[c_PTR_W-1:0] - c_PTR_W'(1);

    always_comb begin
        w_mem_we     = 1'b0;
        w_mem_idx    = w_wr_idx;
        w_next_count = r_count;
        w_set_ovf    = 1'b0;
        w_set_udf    = 1'b0;
        case ({push, pop})
            2'b10: begin
                if (!w_full) begin
                    w_mem_we     = 1'b1;
                    w_next_count = r_count + CNT_W'(1);
                end else begin
                    w_set_ovf = 1'b1;
                end
            end
            2'b01: begin
                if (!w_empty) begin
                    w_next_count = r_count - CNT_W'(1);
                end else begin
                    w_set_udf = 1'b1;
                end
            end
            2'b11: begin
                // Call-and-return in one cycle: overwrite the top in place.
                // On an empty stack there is no top, so it degrades to a push.
                w_mem_we = 1'b1;
                if (!w_empty) begin
                    w_mem_idx = w_top_idx;
                end else begin
                    w_next_count = CNT_W'(1);
                    w_set_udf    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_count     <= w_next_count;
            r_overflow  <= w_set_ovf | (r_overflow  & ~clrErr);
            r_underflow <= w_set_udf | (r_underflow & ~clrErr);
        end
    end

    // Storage is never cleared; reset only blocks writes.
    always_ff @(posedge clk) begin
        if (w_mem_we && !rst) begin
            r_mem[w_mem_idx] <= pushData;
        end
    end

    assign top       = w_empty ? '0 : r_mem[w_top_idx];
    assign count     = r_count;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_return_stack.sv
`default_nettype none
// ============================================================================
// Module      : tb_return_stack
// Description : Self-checking bench for return_stack: directed vector table,
//               hand-written corner sequences and randomized model compare.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_return_stack;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              push = 1'b0;
    logic              pop = 1'b0;
    logic              clrErr = 1'b0;
    logic [ADDR_W-1:0] pushData = '0;
    logic [ADDR_W-1:0] top;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;

    int checks = 0;
    int errors = 0;

    return_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .pushData(pushData),
        .clrErr(clrErr), .top(top), .count(count), .empty(empty), .full(full),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit              rst;
        bit              push;
        bit              pop;
        bit              clr;
        logic [ADDR_W-1:0] d;
        logic [ADDR_W-1:0] top;
        int              cnt;
        bit              ovf;
        bit              udf;
    } vec_t;

    vec_t tbl[$];

    // Reference model: a plain queue whose back element is the top of stack.
    logic [ADDR_W-1:0] mq[$];
    bit                mo;
    bit                mu;

    task automatic add(input bit r, input bit p, input bit o, input bit c,
                       input logic [ADDR_W-1:0] d, input logic [ADDR_W-1:0] et,
                       input int ec, input bit eo, input bit eu);
        vec_t v;
        v = '{r, p, o, c, d, et, ec, eo, eu};
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit p, input bit o, input bit c,
                        input logic [ADDR_W-1:0] d);
        rst = r; push = p; pop = o; clrErr = c; pushData = d;
        @(posedge clk);
        #1;
        rst = 1'b0; push = 1'b0; pop = 1'b0; clrErr = 1'b0;
    endtask

    task automatic check_all(input string tag, input logic [ADDR_W-1:0] et,
                             input int ec, input bit eo, input bit eu);
        chk({tag, ".top"},       32'(top),       32'(et));
        chk({tag, ".count"},     32'(count),     32'(ec));
        chk({tag, ".empty"},     32'(empty),     32'(ec == 0));
        chk({tag, ".full"},      32'(full),      32'(ec == DEPTH));
        chk({tag, ".overflow"},  32'(overflow),  32'(eo));
        chk({tag, ".underflow"}, 32'(underflow), 32'(eu));
    endtask

    task automatic model(input bit r, input bit p, input bit o, input bit c,
                         input logic [ADDR_W-1:0] d);
        bit no, nu;
        no = 1'b0; nu = 1'b0;
        if (r) begin
            mq.delete();
            mo = 1'b0;
            mu = 1'b0;
        end else begin
            if (p && !o) begin
                if (mq.size() < DEPTH) mq.push_back(d);
                else                   no = 1'b1;
            end else if (!p && o) begin
                if (mq.size() > 0) void'(mq.pop_back());
                else               nu = 1'b1;
            end else if (p && o) begin
                if (mq.size() > 0) mq[mq.size()-1] = d;
                else begin
                    mq.push_back(d);
                    nu = 1'b1;
                end
            end
            mo = no | (mo & !c);
            mu = nu | (mu & !c);
        end
    endtask

    initial begin
        // Directed vectors: {rst,push,pop,clr,data} -> {top,count,ovf,udf}
        add(1,0,0,0, 12'h000, 12'h000, 0, 0, 0);
        for (int k = 0; k < 3; k++) add(0,0,0,0, 12'h000, 12'h000, 0, 0, 0);
        add(0,1,0,0, 12'h010, 12'h010, 1, 0, 0);
        add(0,1,0,0, 12'h020, 12'h020, 2, 0, 0);
        add(0,1,0,0, 12'h030, 12'h030, 3, 0, 0);
        add(0,0,1,0, 12'h000, 12'h020, 2, 0, 0);
        add(0,0,1,0, 12'h000, 12'h010, 1, 0, 0);
        add(0,0,1,0, 12'h000, 12'h000, 0, 0, 0);
        for (int k = 0; k < 8; k++)
            add(0,1,0,0, 12'(12'h100 + k), 12'(12'h100 + k), k + 1, 0, 0);
        add(0,1,0,0, 12'h1FF, 12'h107, 8, 1, 0);
        add(0,0,0,1, 12'h000, 12'h107, 8, 0, 0);
        add(1,0,0,0, 12'h000, 12'h000, 0, 0, 0);
        add(0,0,1,0, 12'h000, 12'h000, 0, 0, 1);
        add(0,1,0,0, 12'h055, 12'h055, 1, 0, 1);
        add(1,0,0,0, 12'h000, 12'h000, 0, 0, 0);
        add(0,1,0,0, 12'h011, 12'h011, 1, 0, 0);
        add(0,1,0,0, 12'h022, 12'h022, 2, 0, 0);
        add(0,1,1,0, 12'hABC, 12'hABC, 2, 0, 0);
        add(0,0,1,0, 12'h000, 12'h011, 1, 0, 0);
        add(1,0,0,0, 12'h000, 12'h000, 0, 0, 0);
        add(0,1,1,0, 12'h123, 12'h123, 1, 0, 1);
        add(1,0,0,0, 12'h000, 12'h000, 0, 0, 0);
        for (int k = 1; k <= 5; k++)
            add(0,1,0,0, 12'(k), 12'(k), k, 0, 0);
        add(1,1,0,0, 12'h777, 12'h000, 0, 0, 0);
        add(0,1,0,0, 12'h0AA, 12'h0AA, 1, 0, 0);

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].push, tbl[i].pop, tbl[i].clr, tbl[i].d);
            check_all($sformatf("vec%0d", i), tbl[i].top, tbl[i].cnt, tbl[i].ovf, tbl[i].udf);
        end

        // Full stack: replace-top, then error flag racing with clrErr.
        step(1,0,0,0, 12'h000);
        for (int k = 0; k < DEPTH; k++) step(0,1,0,0, 12'(12'h200 + k));
        check_all("fill", 12'h207, 8, 0, 0);
        step(0,1,1,0, 12'h3EE);
        check_all("full_replace", 12'h3EE, 8, 0, 0);
        step(0,1,0,0, 12'h3FF);
        check_all("full_push", 12'h3EE, 8, 1, 0);
        step(0,1,0,1, 12'h3FF);
        check_all("ovf_vs_clr", 12'h3EE, 8, 1, 0);
        step(0,0,0,1, 12'h000);
        check_all("ovf_clr", 12'h3EE, 8, 0, 0);
        for (int k = 0; k < DEPTH; k++) step(0,0,1,0, 12'h000);
        check_all("drain", 12'h000, 0, 0, 0);
        step(0,0,1,1, 12'h000);
        check_all("udf_vs_clr", 12'h000, 0, 0, 1);
        step(0,0,0,1, 12'h000);
        check_all("udf_clr", 12'h000, 0, 0, 0);

        // Randomized traffic against the queue model.
        step(1,0,0,0, 12'h000);
        model(1,0,0,0, 12'h000);
        for (int n = 0; n < 3000; n++) begin
            bit r, p, o, c;
            logic [ADDR_W-1:0] d;
            r = ($urandom_range(0, 99) == 0);
            p = ($urandom_range(0, 99) < 55);
            o = ($urandom_range(0, 99) < 45);
            c = ($urandom_range(0, 19) == 0);
            d = ADDR_W'($urandom);
            step(r, p, o, c, d);
            model(r, p, o, c, d);
            check_all($sformatf("rand%0d", n), (mq.size() > 0) ? mq[mq.size()-1] : '0,
                      mq.size(), mo, mu);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/return_stack.md
Name: return_stack

Overview:
- Hardware return-address stack. It is the responder for the CPU's push/pop call/return interface.
- On a call, the CPU asserts push with the return PC. On ret, it asserts pop and jumps to the address shown on top.
- Sits beside the controller/datapath pair inside the cpu top.
- Provides occupancy status and sticky error flags, so halt/debug logic can detect runaway recursion or an unmatched ret.

Parameters:
- ADDR_W, 12, width of a stored return address (matches the 12-bit pc).
- DEPTH, 8, number of entries; must be a power of two, at least 2.
- CNT_W, 4, width of count; must be at least log2(DEPTH)+1.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- push  input  1  store pushData as the new top this cycle.
- pop  input  1  discard the current top this cycle.
- pushData  input  ADDR_W  return address to store (pc+1 from the datapath).
- clrErr  input  1  synchronous clear of the overflow and underflow flags.
- top  output  ADDR_W  current top entry; 0 when empty.
- count  output  CNT_W  number of valid entries, 0..DEPTH.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- overflow  output  1  sticky; a push was dropped because the stack was full.
- underflow  output  1  sticky; a pop was issued while the stack was empty.

Behaviour:
- Interface: all-synchronous, no handshake. push and pop are single-cycle strobes sampled at the rising edge of clk.
- State: storage array mem[0..DEPTH-1] of ADDR_W bits, plus a stack pointer sp equal to count. Entries below sp are valid.
- Reset (rst=1 at an edge): count=0, overflow=0, underflow=0. Outputs become top=0, empty=1, full=0.
  - mem contents are not cleared.
  - rst has priority over push, pop and clrErr in the same cycle.
  - A reset arriving mid-sequence discards all entries.
- top is combinational from registered state: mem[sp-1] when count>0, else 0.
  - Latency: a push or pop at edge N is reflected on top, count, empty and full immediately after edge N, with zero wait cycles.
- Operation per edge (rst=0), keyed on {push,pop}:
  - 00: no change.
  - 10, not full: mem[sp]=pushData; count+1.
  - 10, full: storage and count unchanged; overflow=1.
  - 01, not empty: count-1. The old entry remains in mem but is no longer visible.
  - 01, empty: no change to storage or count; underflow=1; top stays 0.
  - 11, not empty (including full): replace the top, mem[sp-1]=pushData; count unchanged; no flag set.
  - 11, empty: behaves as push (mem[0]=pushData, count=1); underflow=1.
- Sticky flags:
  - Cleared only by rst or clrErr.
  - If clrErr and a new error occur in the same cycle, the new error wins and the flag reads 1 after the edge.
- Arithmetic:
  - sp indexes with its low log2(DEPTH) bits.
  - count never exceeds DEPTH and never wraps below 0. Guards are required because count is CNT_W bits.
- Flag timing: empty and full are decoded from the registered count, with no extra cycle of latency.

Test Plan:
- Reset then idle: rst=1 for 1 cycle, then 3 idle cycles -> count=0, empty=1, full=0, top=0, overflow=0, underflow=0.
- Push 0x010, 0x020, 0x030 on consecutive cycles, then pop 3 times.
  - After the pushes: count=3 and top=0x030.
  - After the pops: top reads 0x020, 0x010, 0, count reaches 0 and empty=1. No flags set.
- Overflow: push 0x100..0x107 (8 pushes), giving full=1 and top=0x107. Push 0x1FF next -> overflow=1, count=8, top still 0x107. Pulse clrErr -> overflow=0.
- Underflow: from reset, pop once -> underflow=1, count=0, top=0. Push 0x055 -> top=0x055 and underflow still 1 (sticky).
- Simultaneous push and pop:
  - With 2 entries (0x011, 0x022), push=pop=1 with pushData=0xABC -> count=2, top=0xABC; then pop -> top=0x011.
  - From empty, push=pop=1 with pushData=0x123 -> count=1, top=0x123, underflow=1.
- Reset mid-operation: after pushes of 0x001..0x005, assert rst in the same cycle as push=1 (pushData=0x777) -> count=0, top=0, empty=1. The next push of 0x0AA gives top=0x0AA and count=1.
